// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and access owner.
// The ARB_FAIRNESS_EN build option does not change anything in this package.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter side,
// master = pipeline/memory side. Unaffected by ARB_FAIRNESS_EN.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic [DW-1:0] o_if_rdata;
    logic          o_if_done;

    logic          i_dm_read;
    logic          i_dm_write;
    logic [AW-1:0] i_dm_addr;
    logic [DW-1:0] i_dm_wdata;
    logic [3:0]    i_dm_be;
    logic [DW-1:0] o_dm_rdata;
    logic          o_dm_done;
    logic          o_pipe_stall;

    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [3:0]    o_mem_be;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_rdata, o_if_done,
        input  i_dm_read, i_dm_write, i_dm_addr, i_dm_wdata, i_dm_be,
        output o_dm_rdata, o_dm_done, o_pipe_stall,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_ack, i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_rdata, o_if_done,
        output i_dm_read, i_dm_write, i_dm_addr, i_dm_wdata, i_dm_be,
        input  o_dm_rdata, o_dm_done, o_pipe_stall,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_ack, i_mem_rdata
    );

endinterface

// File: rtl/arb_streak_ctr.sv
// Grant select for the arbiter. With ARB_FAIRNESS_EN defined, a saturating
// data-streak counter forces an IF grant after MAX_D_STREAK data wins.
module arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_arb_en,
    input  logic       i_if_req,
    input  logic       i_dm_req,
    output logic       o_grant,
    output arb_owner_e o_owner
);

`ifdef ARB_FAIRNESS_EN
    localparam int CW = $clog2(MAX_D_STREAK + 1);

    logic [CW-1:0] streak_q;
    logic          force_if;

    assign force_if = (streak_q == CW'(MAX_D_STREAK)) && i_if_req && i_dm_req;

    always_comb begin
        o_grant = i_arb_en && (i_if_req || i_dm_req);
        o_owner = (i_dm_req && !force_if) ? OWN_DM : OWN_IF;
    end

    // Only data wins that keep a pending fetch waiting extend the streak.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            streak_q <= '0;
        end else if (o_grant) begin
            if (o_owner == OWN_IF || !i_if_req) begin
                streak_q <= '0;
            end else if (streak_q != CW'(MAX_D_STREAK)) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = i_clk ^ i_rst_n ^ (MAX_D_STREAK == 0);

    always_comb begin
        o_grant = i_arb_en && (i_if_req || i_dm_req);
        o_owner = i_dm_req ? OWN_DM : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between fetch and data accesses; data wins.
// Define ARB_FAIRNESS_EN to bound how long data can starve a waiting fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    mem_port_arbiter_if.slave  bus
);

    arb_state_e    state_q, state_d;
    arb_owner_e    owner_q, grant_owner;
    logic          grant;
    logic          dm_req;

    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic          if_done_q;
    logic          dm_done_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    assign dm_req = bus.i_dm_read | bus.i_dm_write;

    arb_streak_ctr #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_sel (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_arb_en (state_q == IDLE),
        .i_if_req (bus.i_if_req),
        .i_dm_req (dm_req),
        .o_grant  (grant),
        .o_owner  (grant_owner)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  if (bus.i_mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are latched once at grant so they stay stable across wait states.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            mem_req_q <= (state_d == ACCESS);
            if (state_q == IDLE && grant) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_DM) begin
                    mem_we_q    <= bus.i_dm_write;
                    mem_addr_q  <= bus.i_dm_addr;
                    mem_wdata_q <= bus.i_dm_wdata;
                    mem_be_q    <= bus.i_dm_be;
                end else begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= bus.i_if_addr;
                    mem_wdata_q <= '0;
                    mem_be_q    <= 4'b1111;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            if (state_q == ACCESS && bus.i_mem_ack) begin
                if (owner_q == OWN_DM) begin
                    dm_done_q  <= 1'b1;
                    dm_rdata_q <= bus.i_mem_rdata;
                end else begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= bus.i_mem_rdata;
                end
            end
        end
    end

    assign bus.o_mem_req    = mem_req_q;
    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_wdata  = mem_wdata_q;
    assign bus.o_mem_be     = mem_be_q;
    assign bus.o_if_done    = if_done_q;
    assign bus.o_if_rdata   = if_rdata_q;
    assign bus.o_dm_done    = dm_done_q;
    assign bus.o_dm_rdata   = dm_rdata_q;
    assign bus.o_pipe_stall = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW           (32),
        .DW           (32),
        .MAX_D_STREAK (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    bit          ack_hold = 1'b0;
    bit          prev_req = 1'b0;
    logic [31:0] rdata_next = 32'h1111_2222;
    logic [31:0] grant_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit is_dm, input string tag);
        int n = 0;
        while (!(is_dm ? bus.o_dm_done : bus.o_if_done) && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 50), 64'd1);
    endtask

    // Memory model: ack after ack_delay extra cycles unless held off.
    initial begin
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.o_mem_req && !prev_req) begin
                grant_log.push_back(bus.o_mem_addr);
                wcnt = 0;
            end
            if (bus.o_mem_req && !ack_hold) begin
                bus.i_mem_ack   = (wcnt == ack_delay);
                bus.i_mem_rdata = rdata_next;
                wcnt++;
            end else begin
                bus.i_mem_ack = 1'b0;
            end
            prev_req = bus.o_mem_req;
        end
    end

    initial begin
        int n_dm, n_if, n, base;
        int if_pos;
        logic [31:0] exp_addr;

        rst_n          = 1'b0;
        bus.i_if_req   = 1'b1;
        bus.i_if_addr  = 32'h0040_0000;
        bus.i_dm_read  = 1'b1;
        bus.i_dm_write = 1'b0;
        bus.i_dm_addr  = 32'h1000_0000;
        bus.i_dm_wdata = '0;
        bus.i_dm_be    = 4'b1111;

        // Reset with both requesters pending
        tick();
        tick();
        check("rst_mem_req", 64'(bus.o_mem_req), 64'd0);
        check("rst_mem_we", 64'(bus.o_mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
        check("rst_if_done", 64'(bus.o_if_done), 64'd0);
        check("rst_dm_done", 64'(bus.o_dm_done), 64'd0);
        check("rst_if_rdata", 64'(bus.o_if_rdata), 64'd0);
        check("rst_dm_rdata", 64'(bus.o_dm_rdata), 64'd0);
        rst_n = 1'b1;
        check("rel_mem_req_lo", 64'(bus.o_mem_req), 64'd0);
        tick();
        check("rel_mem_req_hi", 64'(bus.o_mem_req), 64'd1);
        check("rel_dm_first", 64'(bus.o_mem_addr), 64'h1000_0000);
        wait_pulse(1'b1, "rel_dm");
        check("rel_dm_rdata", 64'(bus.o_dm_rdata), 64'h1111_2222);
        bus.i_dm_read = 1'b0;
        rdata_next    = 32'h3333_4444;
        wait_pulse(1'b0, "rel_if");
        check("rel_if_rdata", 64'(bus.o_if_rdata), 64'h3333_4444);
        bus.i_if_req = 1'b0;
        tick();
        tick();

        // Fetch, zero wait states
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0040_0000;
        rdata_next    = 32'h2008_0005;
        tick();
        check("f0_mem_req", 64'(bus.o_mem_req), 64'd1);
        check("f0_mem_we", 64'(bus.o_mem_we), 64'd0);
        check("f0_mem_addr", 64'(bus.o_mem_addr), 64'h0040_0000);
        tick();
        check("f0_if_done", 64'(bus.o_if_done), 64'd1);
        check("f0_if_rdata", 64'(bus.o_if_rdata), 64'h2008_0005);
        check("f0_req_drop", 64'(bus.o_mem_req), 64'd0);
        bus.i_if_req = 1'b0;
        tick();
        check("f0_done_pulse", 64'(bus.o_if_done), 64'd0);
        check("f0_rdata_hold", 64'(bus.o_if_rdata), 64'h2008_0005);
        tick();

        // Contention: data first, fetch request at T+4
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0040_0004;
        bus.i_dm_read = 1'b1;
        bus.i_dm_addr = 32'h1000_0004;
        rdata_next    = 32'hA5A5_0001;
        tick();
        check("ct_t1_req", 64'(bus.o_mem_req), 64'd1);
        check("ct_t1_addr", 64'(bus.o_mem_addr), 64'h1000_0004);
        tick();
        check("ct_t2_dm_done", 64'(bus.o_dm_done), 64'd1);
        check("ct_t2_stall", 64'(bus.o_pipe_stall), 64'd0);
        bus.i_dm_read = 1'b0;
        tick();
        check("ct_t3_req", 64'(bus.o_mem_req), 64'd0);
        tick();
        check("ct_t4_req", 64'(bus.o_mem_req), 64'd1);
        check("ct_t4_addr", 64'(bus.o_mem_addr), 64'h0040_0004);
        tick();
        check("ct_if_done", 64'(bus.o_if_done), 64'd1);
        bus.i_if_req = 1'b0;
        tick();

        // Store with wait states
        ack_delay      = 2;
        bus.i_dm_write = 1'b1;
        bus.i_dm_addr  = 32'h1000_0010;
        bus.i_dm_wdata = 32'hDEAD_BEEF;
        bus.i_dm_be    = 4'b1111;
        #1;
        check("st_stall_pre", 64'(bus.o_pipe_stall), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("st_req_%0d", i), 64'(bus.o_mem_req), 64'd1);
            check($sformatf("st_we_%0d", i), 64'(bus.o_mem_we), 64'd1);
            check($sformatf("st_addr_%0d", i), 64'(bus.o_mem_addr), 64'h1000_0010);
            check($sformatf("st_wdata_%0d", i), 64'(bus.o_mem_wdata), 64'hDEAD_BEEF);
            check($sformatf("st_be_%0d", i), 64'(bus.o_mem_be), 64'hF);
            check($sformatf("st_stall_%0d", i), 64'(bus.o_pipe_stall), 64'd1);
        end
        tick();
        check("st_dm_done", 64'(bus.o_dm_done), 64'd1);
        check("st_req_drop", 64'(bus.o_mem_req), 64'd0);
        check("st_stall_end", 64'(bus.o_pipe_stall), 64'd0);
        bus.i_dm_write = 1'b0;
        ack_delay      = 0;
        tick();

        // Fetch flushed before it could be granted
        base          = grant_log.size();
        ack_hold      = 1'b1;
        bus.i_dm_read = 1'b1;
        bus.i_dm_addr = 32'h1000_0020;
        rdata_next    = 32'h5555_6666;
        tick();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0040_0100;
        tick();
        bus.i_if_req = 1'b0;
        ack_hold     = 1'b0;
        wait_pulse(1'b1, "fl_dm");
        bus.i_dm_read = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(bus.o_if_done) + int'(bus.o_mem_req);
        end
        check("fl_no_if_access", 64'(n), 64'd0);
        check("fl_grant_count", 64'(grant_log.size() - base), 64'd1);

        // Reset while the access waits for ack
        ack_hold      = 1'b1;
        bus.i_dm_read = 1'b1;
        bus.i_dm_addr = 32'h1000_0030;
        tick();
        check("ra_req_up", 64'(bus.o_mem_req), 64'd1);
        rst_n = 1'b0;
        tick();
        check("ra_req_drop", 64'(bus.o_mem_req), 64'd0);
        check("ra_dm_rdata", 64'(bus.o_dm_rdata), 64'd0);
        check("ra_if_rdata", 64'(bus.o_if_rdata), 64'd0);
        bus.i_dm_read = 1'b0;
        rst_n         = 1'b1;
        ack_hold      = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n += int'(bus.o_dm_done) + int'(bus.o_mem_req);
        end
        check("ra_no_done", 64'(n), 64'd0);

        // Six back-to-back data requests with fetch held
        base          = grant_log.size();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0040_0200;
        bus.i_dm_read = 1'b1;
        bus.i_dm_addr = 32'h1000_0040;
        n_dm = 0;
        n_if = 0;
        n    = 0;
        while ((bus.i_dm_read || bus.i_if_req) && n < 100) begin
            tick();
            n++;
            if (bus.o_dm_done) begin
                n_dm++;
                if (n_dm == 6) bus.i_dm_read = 1'b0;
            end
            if (bus.o_if_done) begin
                n_if++;
                bus.i_if_req = 1'b0;
            end
        end
        check("fair_timeout", 64'(n < 100), 64'd1);
        check("fair_dm_cnt", 64'(n_dm), 64'd6);
        check("fair_if_cnt", 64'(n_if), 64'd1);
        check("fair_grants", 64'(grant_log.size() - base), 64'd7);
`ifdef ARB_FAIRNESS_EN
        if_pos = 4;
`else
        if_pos = 6;
`endif
        for (int i = 0; i < 7; i++) begin
            exp_addr = (i == if_pos) ? 32'h0040_0200 : 32'h1000_0040;
            if (base + i < grant_log.size())
                check($sformatf("fair_grant_%0d", i), 64'(grant_log[base + i]), 64'(exp_addr));
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between instruction fetch (IF) and the MEM-stage data access of the pipeline. Data requests are driven by the decoder's memread/memwrite controls. The block grants one requester at a time and sequences a req/ack access to memory that may include wait states. Completion is reported to the requester as a one-cycle done pulse, which the pipeline uses to stall. An optional streak limiter prevents a run of loads/stores from starving fetch.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while IF is waiting; `ARB_FAIRNESS_EN` only
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_if_req  in  1  fetch request; held with i_if_addr until o_if_done
- i_if_addr  in  AW  fetch address
- o_if_rdata  out  DW  fetched word; valid while o_if_done
- o_if_done  out  1  one-cycle fetch completion pulse
- i_dm_read / i_dm_write  in  1 each  load / store request (decoder memread/memwrite)
- i_dm_addr  in  AW  data address
- i_dm_wdata  in  DW  store data
- i_dm_be  in  4  byte enables
- o_dm_rdata  out  DW  load data; valid while o_dm_done
- o_dm_done  out  1  one-cycle data completion pulse
- o_pipe_stall  out  1  (i_dm_read|i_dm_write) & ~o_dm_done
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write
- o_mem_addr / o_mem_wdata  out  AW / DW  registered address and write data
- o_mem_be  out  4  registered byte enables
- i_mem_ack  in  1  access complete in this cycle
- i_mem_rdata  in  DW  read data; valid with i_mem_ack

## Operation
- FSM states:
  - IDLE: arbitrate. On a grant, latch the owner plus addr/wdata/be/we and go to ACCESS.
  - ACCESS: o_mem_req=1. On i_mem_ack, capture i_mem_rdata and go to DONE.
  - DONE: pulse the owner's done; go to IDLE.
- Priority: data over fetch (data belongs to the older instruction).
- Read and write asserted together is illegal; treated as a write.
- A request dropped before grant (e.g. IF flush) is never served.
- Once granted, an access always completes. The done pulse is still issued after the requester drops its request; the requester ignores it.
- Request signals are not sampled in ACCESS or DONE.
- o_if_rdata and o_dm_rdata hold their last captured value between accesses.
- Reset values: all outputs 0, rdata registers 0, state IDLE, streak counter 0.
- Reset mid-access: the FSM returns to IDLE and o_mem_req drops the next cycle. Memory must tolerate an abandoned request.

## Timing
- Grant occurs in IDLE at cycle T; o_mem_req rises at T+1.
- ack at cycle A gives done at A+1, with o_mem_req=0 at A+1.
- Minimum access is 3 cycles with ack at T+1. The next grant can occur at T+3.
- o_mem_addr, o_mem_wdata, o_mem_be and o_mem_we stay stable for the whole ACCESS state.
- All outputs except o_pipe_stall are registered.

## Configuration
- `ARB_FAIRNESS_EN` defined:
  - A saturating streak counter, sized $clog2(MAX_D_STREAK+1), increments on each data grant made while i_if_req=1.
  - It clears on an IF grant, or on a data grant made while i_if_req=0.
  - When the count equals MAX_D_STREAK and both requesters are pending, IF is granted.
- `ARB_FAIRNESS_EN` undefined: strict data priority and no counter logic.

## Structure
- Package mem_arb_pkg: the state enum (IDLE, ACCESS, DONE) and the owner enum (OWN_IF, OWN_DM).
- One sub-module, arb_streak_ctr: grant select plus streak counter. Its counter is compiled out without `ARB_FAIRNESS_EN`.

## Test plan
- Reset: i_rst_n=0 for 2 cycles with i_if_req=1 and i_dm_read=1 → all outputs 0. The first grant comes one cycle after release: data wins, o_mem_req=1 two cycles after release.
- Fetch, zero wait: i_if_req at T, addr 0x0040_0000, ack at T+1 with rdata 0x2008_0005 → o_mem_req/o_mem_we=1/0 at T+1; o_if_done=1 and o_if_rdata=0x2008_0005 at T+2.
- Contention: i_if_req and i_dm_read both high at T → data access at T+1; fetch o_mem_req at T+4 (ack same cycle each time).
- Store with wait states: i_dm_write, addr 0x1000_0010, wdata 0xDEAD_BEEF, be 4'b1111, ack 3 cycles after req → o_mem_req held 3 cycles with stable bus. o_dm_done on the cycle after ack. o_pipe_stall high until that done.
- Fairness, MAX_D_STREAK=4: i_if_req held, 6 back-to-back data requests → with macro, the 5th grant goes to IF. Without macro, IF is granted after all 6.
- Reset in ACCESS, plus IF flush: i_rst_n=0 while ack is withheld → o_mem_req=0 the next cycle and no done pulse. Separately, i_if_req dropped before grant → no memory access issued.
